// File: rtl/transfer_rr.sv
`default_nettype none
// ============================================================================
// Module   : transfer_rr
// Brief    : Round-robin serialiser of N channel words onto one 8N1 UART line,
//            with an optional channel-index header byte per frame.
// Revision : 1.0 - initial release
// ============================================================================
module transfer_rr #(
  parameter int N_CHANNELS     = 4,
  parameter int WORD_WIDTH     = 32,
  parameter int BAUD_PRESCALER = 5,
  parameter int HEADER_EN      = 1
) (
  input  logic                             i_clk,
  input  logic                             rst,
  input  logic [N_CHANNELS*WORD_WIDTH-1:0] data_in,
  input  logic [N_CHANNELS-1:0]            available,
  output logic [N_CHANNELS-1:0]            read,
  output logic                             o_tx,
  output logic                             busy
);

  localparam int C_IW     = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int C_NBYTES = ((HEADER_EN != 0) ? 1 : 0) + WORD_WIDTH / 8;
  localparam int C_FW     = C_NBYTES * 8;
  localparam int C_CW     = (BAUD_PRESCALER > 1) ? $clog2(BAUD_PRESCALER) : 1;
  localparam int C_BW     = $clog2(C_NBYTES + 1);
  localparam logic [C_CW-1:0] C_BAUD_LAST = C_CW'(BAUD_PRESCALER - 1);
  localparam logic [C_BW-1:0] C_BYTE_LAST = C_BW'(C_NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state;
  logic [C_IW-1:0]   r_ptr;
  logic [7:0]        r_byte;
  logic [C_FW-1:0]   r_rest;
  logic [C_CW-1:0]   r_baud;
  logic [2:0]        r_bit;
  logic [C_BW-1:0]   r_bytes;

  logic [C_IW-1:0]       w_grant;
  logic [C_IW-1:0]       w_ptr_next;
  logic                  w_found;
  int                    w_idx;
  logic [WORD_WIDTH-1:0] w_word;
  logic [C_FW-1:0]       w_frame;
  logic                  w_bit_end;

  // First requesting channel at or after the pointer, wrapping modulo N.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      w_idx = (int'(r_ptr) + i) % N_CHANNELS;
      if (!w_found && available[w_idx]) begin
        w_found = 1'b1;
        w_grant = C_IW'(w_idx);
      end
    end
  end

  assign w_ptr_next = (int'(w_grant) == N_CHANNELS - 1) ? '0 : w_grant + C_IW'(1);
  assign w_word     = data_in[int'(w_grant)*WORD_WIDTH +: WORD_WIDTH];
  assign w_bit_end  = (r_baud == C_BAUD_LAST);

  generate
    if (HEADER_EN != 0) begin : g_hdr
      assign w_frame = {8'(w_grant), w_word};
    end else begin : g_nohdr
      assign w_frame = w_word;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_byte  <= '0;
      r_rest  <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_bytes <= '0;
      read    <= '0;
      o_tx    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      read <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            read[w_grant] <= 1'b1;
            r_byte  <= w_frame[C_FW-1 -: 8];
            r_rest  <= w_frame << 8;
            r_ptr   <= w_ptr_next;
            r_baud  <= '0;
            r_bytes <= '0;
            r_state <= S_START;
            o_tx    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            o_tx    <= r_byte[0];
            r_byte  <= r_byte >> 1;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + C_CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              o_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit  <= r_bit + 3'd1;
              o_tx   <= r_byte[0];
              r_byte <= r_byte >> 1;
            end
          end else begin
            r_baud <= r_baud + C_CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            // Returning through IDLE guarantees the one-cycle inter-frame gap.
            if (r_bytes == C_BYTE_LAST) begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_bytes <= r_bytes + C_BW'(1);
              r_byte  <= r_rest[C_FW-1 -: 8];
              r_rest  <= r_rest << 8;
              o_tx    <= 1'b0;
              r_state <= S_START;
            end
          end else begin
            r_baud <= r_baud + C_CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_transfer_rr.sv
`default_nettype none
// Bench for transfer_rr: table-driven frame checks on a 4x32 header instance,
// plus hand sequences for mid-frame reset and a 2x16 no-header P=1 instance.
module tb_transfer_rr;

  localparam logic [127:0] D = 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] data_in;
  logic [3:0]   available;
  logic [3:0]   read;
  logic         tx, busy;
  logic [31:0]  data2;
  logic [1:0]   avail2;
  logic [1:0]   read2;
  logic         tx2, busy2;

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  logic [3:0] cur_read;
  logic       cur_tx, cur_busy;

  always #5 clk = ~clk;

  transfer_rr #(.N_CHANNELS(4), .WORD_WIDTH(32), .BAUD_PRESCALER(5), .HEADER_EN(1)) u_dut (
    .i_clk(clk), .rst(rst), .data_in(data_in), .available(available),
    .read(read), .o_tx(tx), .busy(busy));

  transfer_rr #(.N_CHANNELS(2), .WORD_WIDTH(16), .BAUD_PRESCALER(1), .HEADER_EN(0)) u_dut2 (
    .i_clk(clk), .rst(rst), .data_in(data2), .available(avail2),
    .read(read2), .o_tx(tx2), .busy(busy2));

  always_comb begin
    cur_read = read;
    cur_tx   = tx;
    cur_busy = busy;
    if (sel == 1) begin
      cur_read = {2'b00, read2};
      cur_tx   = tx2;
      cur_busy = busy2;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_read(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cur_read == 4'b0 && n < 2000);
    check("read_arrives", 64'(cur_read != 4'b0), 64'd1);
  endtask

  // Called at the negedge of the read-pulse cycle (first start-bit cycle).
  task automatic check_frame(input string tag, input logic [3:0] exp_read,
                             input logic [39:0] frame, input int nbytes, input int p);
    int errs, d, bi, b, k, first_t;
    logic [7:0] bytev;
    logic       expb;
    errs    = 0;
    first_t = -1;
    d       = nbytes * 10 * p;
    check({tag, "_read"}, 64'(cur_read), 64'(exp_read));
    for (int t = 0; t < d; t++) begin
      if (t > 0) @(negedge clk);
      bi    = t / p;
      b     = bi / 10;
      k     = bi % 10;
      bytev = frame[(nbytes-1-b)*8 +: 8];
      expb  = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bytev[k-1];
      if (cur_tx !== expb || cur_busy !== 1'b1 || (t > 0 && cur_read != 4'b0)) begin
        if (errs == 0) first_t = t;
        errs++;
      end
    end
    if (errs != 0) $display("  %s first bad cycle %0d", tag, first_t);
    check({tag, "_frame_errs"}, 64'(errs), 64'd0);
    @(negedge clk);
    check({tag, "_gap"}, 64'({cur_tx, cur_busy, cur_read}), 64'({1'b1, 1'b0, 4'b0000}));
  endtask

  typedef struct {
    bit           pre;
    logic [3:0]   avail_pre;
    logic [3:0]   exp_read;
    logic [39:0]  frame;
    logic [3:0]   avail_post;
    logic [127:0] data_post;
    int           gap;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, errs;
    logic [19:0] cap;

    vecs[0] = '{1'b1, 4'b0100, 4'b0100, 40'h02BBBBBBBB, 4'b0000, D, -1};
    vecs[1] = '{1'b1, 4'b1111, 4'b0001, 40'h00DDDDDDDD, 4'b1111, D, -1};
    vecs[2] = '{1'b0, 4'b0000, 4'b0010, 40'h01CCCCCCCC, 4'b1111, D, 1};
    vecs[3] = '{1'b0, 4'b0000, 4'b0100, 40'h02BBBBBBBB, 4'b0101, D, 1};
    vecs[4] = '{1'b0, 4'b0000, 4'b0001, 40'h00DDDDDDDD, 4'b0101, D, 1};
    vecs[5] = '{1'b0, 4'b0000, 4'b0100, 40'h02BBBBBBBB, 4'b1111, D, 1};
    vecs[6] = '{1'b0, 4'b0000, 4'b1000, 40'h03AAAAAAAA, 4'b1111, D, 1};
    vecs[7] = '{1'b0, 4'b0000, 4'b0001, 40'h00DDDDDDDD, 4'b0000, D, 1};
    vecs[8] = '{1'b1, 4'b0100, 4'b0100, 40'h02BBBBBBBB, 4'b0000,
                128'h11111111222222223333333344444444, -1};

    rst       = 1'b1;
    available = 4'b0;
    data_in   = D;
    avail2    = 2'b0;
    data2     = {16'hABCD, 16'h1234};
    repeat (2) @(negedge clk);
    check("reset_state", 64'({tx, busy, read}), 64'({1'b1, 1'b0, 4'b0000}));
    check("reset_state2", 64'({tx2, busy2, read2}), 64'({1'b1, 1'b0, 2'b00}));
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].pre) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        available = vecs[i].avail_pre;
      end
      wait_read(n);
      if (vecs[i].gap >= 0) check($sformatf("v%0d_gap_cycles", i), 64'(n), 64'(vecs[i].gap));
      available = vecs[i].avail_post;
      data_in   = vecs[i].data_post;
      check_frame($sformatf("v%0d", i), vecs[i].exp_read, vecs[i].frame, 5, 5);
    end

    // No further reads once the only requester has dropped.
    errs = 0;
    repeat (30) begin
      @(negedge clk);
      if (read != 4'b0 || tx !== 1'b1) errs++;
    end
    check("quiet_after_drop", 64'(errs), 64'd0);
    data_in = D;

    // Reset during DATA of byte 2 after serving ch2; restart must begin at ptr 0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    available = 4'b0100;
    wait_read(n);
    available = 4'b0000;
    repeat (115) @(negedge clk);
    check("midframe_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midframe_reset", 64'({tx, busy, read}), 64'({1'b1, 1'b0, 4'b0000}));
    available = 4'b1111;
    wait_read(n);
    available = 4'b0000;
    check_frame("restart", 4'b0001, 40'h00DDDDDDDD, 5, 5);

    // No-header, 16-bit, one cycle per bit.
    sel    = 1;
    avail2 = 2'b01;
    wait_read(n);
    avail2 = 2'b00;
    check("p1_read", 64'(read2), 64'(2'b01));
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      cap[19-i] = tx2;
      if (busy2 !== 1'b1) errs++;
    end
    check("p1_bits", 64'(cap), 64'(20'b00100100010001011001));
    check("p1_busy", 64'(errs), 64'd0);
    @(negedge clk);
    check("p1_end", 64'({tx2, busy2}), 64'({1'b1, 1'b0}));

    // Two channels both requesting: ptr sits at 1 after serving ch0.
    avail2 = 2'b11;
    wait_read(n);
    check_frame("n2_ch1", 4'b0010, 40'hABCD, 2, 1);
    wait_read(n);
    check("n2_gap_cycles", 64'(n), 64'd1);
    avail2 = 2'b00;
    check_frame("n2_ch0", 4'b0001, 40'h1234, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
